// File: rtl/pwm_capture_if.sv
// Peripheral-bus view of the PWM capture block.
//   ctrl_in  : [31]=en, [0]=clr (level, clears sticky flags), other bits reserved
//   period_o : {valid, ovf, 3'b0, period[26:0]}
//   high_o   : {valid, ovf, 3'b0, high[26:0]}
//   stuck_o  : {stuck, synced PWM level}
//   done_o   : one-cycle pulse when a new period/high pair is latched
// master = bus side (drives ctrl), slave = capture block.
interface pwm_capture_if;
   logic [31:0] ctrl_in;
   logic [31:0] period_o;
   logic [31:0] high_o;
   logic [1:0]  stuck_o;
   logic        done_o;

   modport master (
      output ctrl_in,
      input  period_o,
      input  high_o,
      input  stuck_o,
      input  done_o
   );

   modport slave (
      input  ctrl_in,
      output period_o,
      output high_o,
      output stuck_o,
      output done_o
   );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input in CLK cycles.
// Results use the generator's register layout: period reads back as top+1, high as cmp.
//   CLK     : clock, all logic on posedge
//   RST     : synchronous reset, active-high
//   PWM_IN  : asynchronous PWM input
//   bus     : control word in, period/high/stuck/done results out (see pwm_capture_if)
// Parameters:
//   CNT_W       : counter/result width, at most 27
//   SYNC_STAGES : input synchronizer depth, at least 2
//   TIMEOUT     : edge-free cycles before STUCK is declared, 1 .. 2^CNT_W-1
module pwm_capture #(
   parameter int unsigned CNT_W       = 27,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 32'h07FF_FFFF
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         PWM_IN,
   pwm_capture_if.slave bus
);

   localparam logic [CNT_W-1:0] CntMax   = '1;
   localparam logic [CNT_W-1:0] TimeoutC = CNT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      StOff,
      StArm,
      StHigh,
      StLow,
      StStuck
   } state_e;

   state_e state_q, state_d;

   // Input synchronizer plus one delay flop for edge detection. Both edges pass
   // through the same pipeline, so measured widths carry no latency skew.
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;
   logic                   s;
   logic                   rise;
   logic                   fall;
   logic                   edge_seen;

   logic en;
   logic clr;
   logic unused_ctrl;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] gap_q, gap_d;
   logic [CNT_W-1:0] hi_tmp_q, hi_tmp_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             ovf_run_q, ovf_run_d;
   logic             skip_q, skip_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;
   logic             stuck_q, stuck_d;
   logic             done_q, done_d;

   logic [CNT_W-1:0] cnt_inc;
   logic             cnt_sat;
   logic [CNT_W-1:0] gap_inc;
   logic             timeout;

   logic [26:0] period_fld;
   logic [26:0] high_fld;

   assign s         = sync_q[SYNC_STAGES-1];
   assign rise      = s & ~dly_q;
   assign fall      = ~s & dly_q;
   assign edge_seen = rise | fall;

   assign en          = bus.ctrl_in[31];
   assign clr         = bus.ctrl_in[0];
   assign unused_ctrl = ^bus.ctrl_in[30:1];

   // Saturating period counter and edge-gap counter increments.
   always_comb begin
      cnt_sat = (cnt_q == CntMax);
      cnt_inc = cnt_sat ? cnt_q : cnt_q + CNT_W'(1);
      if (edge_seen) begin
         gap_inc = '0;
      end else if (gap_q == TimeoutC) begin
         gap_inc = gap_q;
      end else begin
         gap_inc = gap_q + CNT_W'(1);
      end
      // An edge forces gap_inc to zero, so timeout never coincides with an edge.
      timeout = (gap_inc == TimeoutC);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gap_d     = gap_q;
      ovf_run_d = ovf_run_q;
      hi_tmp_d  = hi_tmp_q;
      skip_d    = skip_q;
      period_d  = period_q;
      high_d    = high_q;
      valid_d   = valid_q;
      ovf_d     = ovf_q;
      stuck_d   = stuck_q;
      done_d    = 1'b0;

      if (state_q != StOff) begin
         cnt_d     = rise ? CNT_W'(1) : cnt_inc;
         gap_d     = gap_inc;
         // Overflow is tracked per period: a rise starts a fresh one.
         ovf_run_d = rise ? 1'b0 : (ovf_run_q | cnt_sat);
      end

      // Clear first so that a coinciding update or stuck detection wins.
      if (clr) begin
         valid_d = 1'b0;
         ovf_d   = 1'b0;
         stuck_d = 1'b0;
      end

      if ((state_q != StOff) && !en) begin
         // Partial measurement is dropped; published results are kept.
         state_d   = StOff;
         cnt_d     = '0;
         gap_d     = '0;
         ovf_run_d = 1'b0;
         skip_d    = 1'b0;
      end else begin
         unique case (state_q)
            StOff: begin
               cnt_d     = '0;
               gap_d     = '0;
               ovf_run_d = 1'b0;
               skip_d    = 1'b0;
               if (en) begin
                  state_d = StArm;
               end
            end
            StArm: begin
               // The partial period before the first rise is discarded.
               if (rise) begin
                  state_d = StHigh;
               end else if (timeout) begin
                  state_d = StStuck;
                  stuck_d = 1'b1;
               end
            end
            StHigh: begin
               if (fall) begin
                  hi_tmp_d = cnt_q;
                  state_d  = StLow;
               end else if (timeout) begin
                  state_d = StStuck;
                  stuck_d = 1'b1;
               end
            end
            StLow: begin
               if (rise) begin
                  state_d = StHigh;
                  if (skip_q) begin
                     // High phase began inside STUCK, so hi_tmp is not trustworthy.
                     skip_d = 1'b0;
                  end else begin
                     period_d = cnt_q;
                     high_d   = hi_tmp_q;
                     valid_d  = 1'b1;
                     ovf_d    = ovf_run_q;
                     done_d   = 1'b1;
                  end
               end else if (timeout) begin
                  state_d = StStuck;
                  stuck_d = 1'b1;
               end
            end
            StStuck: begin
               if (rise) begin
                  state_d = StHigh;
                  stuck_d = 1'b0;
               end else if (fall) begin
                  state_d = StLow;
                  skip_d  = 1'b1;
                  stuck_d = 1'b0;
               end
            end
            default: begin
               state_d = StOff;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_q    <= '0;
         dly_q     <= 1'b0;
         state_q   <= StOff;
         cnt_q     <= '0;
         gap_q     <= '0;
         hi_tmp_q  <= '0;
         ovf_run_q <= 1'b0;
         skip_q    <= 1'b0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         ovf_q     <= 1'b0;
         stuck_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], PWM_IN};
         dly_q     <= s;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         hi_tmp_q  <= hi_tmp_d;
         ovf_run_q <= ovf_run_d;
         skip_q    <= skip_d;
         period_q  <= period_d;
         high_q    <= high_d;
         valid_q   <= valid_d;
         ovf_q     <= ovf_d;
         stuck_q   <= stuck_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      period_fld               = '0;
      period_fld[CNT_W-1:0]    = period_q;
      high_fld                 = '0;
      high_fld[CNT_W-1:0]      = high_q;
   end

   assign bus.period_o = {valid_q, ovf_q, 3'b000, period_fld};
   assign bus.high_o   = {valid_q, ovf_q, 3'b000, high_fld};
   assign bus.stuck_o  = {stuck_q, s};
   assign bus.done_o   = done_q;

endmodule
